// File: rtl/ltc_lvds_serializer_if.sv
// Sample stream into the LTC LVDS serializer: valid/ready handshake carrying one W-bit word.
interface ltc_lvds_serializer_if #(
    parameter int W = 16
);
    logic [W-1:0] s_data;
    logic         s_valid;
    logic         s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/ltc_lvds_serializer.sv
// Two-lane LTC-style ADC LVDS emulator: lanes A/B, frame clock and DCO at one slot per sys_clk.
// Define SER_TESTPAT_EN to compile in the tp_en/tp_word test-pattern override.

// One output lane: a SLOTS-deep shift register that emits its MSB every slot.
module ltc_lvds_lane #(
    parameter int SLOTS = 8
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             load,
    input  logic [SLOTS-1:0] load_bits,
    output logic             dout
);
    logic [SLOTS-1:0] sh_q;

    // Non-load cycles shift in 0, which also produces the 0 slot of a bitslip stretch.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset)     sh_q <= '0;
        else if (load) sh_q <= load_bits;
        else           sh_q <= {sh_q[SLOTS-2:0], 1'b0};
    end

    assign dout = sh_q[SLOTS-1];
endmodule

module ltc_lvds_serializer #(
    parameter int           W         = 16,
    parameter logic [W-1:0] IDLE_WORD = '0
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    ltc_lvds_serializer_if.slave s_if,
    input  logic                 bitslip,
    input  logic                 tp_en,
    input  logic [W-1:0]         tp_word,
    output logic                 out_a,
    output logic                 out_b,
    output logic                 frame,
    output logic                 dco,
    output logic [15:0]          underrun_cnt
);
    localparam int NUM_LANES = 2;
    localparam int SLOTS     = W / NUM_LANES;
    localparam int SW        = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef logic [SW-1:0] slot_t;
    localparam slot_t LAST = slot_t'(SLOTS - 1);

    slot_t          fs_q, fs_nxt, ds_q;
    logic           fs_wrap, ds_at_end;
    logic           slip_pend_q, slip_stretch, load_now;
    logic [W-1:0]   hold_q, load_word;
    logic           hold_full_q, hold_pop, accept, tp_sel;
    logic           frame_q, dco_q;
    logic [15:0]    under_q;
    logic [NUM_LANES-1:0] lane_out;

    // ---------------- slot counters ----------------
    assign fs_wrap      = (fs_q == LAST);
    assign fs_nxt       = fs_wrap ? '0 : fs_q + slot_t'(1);
    assign ds_at_end    = (ds_q == LAST);
    // A pending bitslip holds ds at its last slot for one extra cycle before wrapping.
    assign slip_stretch = ds_at_end && slip_pend_q;
    assign load_now     = ds_at_end && !slip_pend_q;

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            fs_q    <= LAST;
            frame_q <= 1'b0;
            dco_q   <= 1'b0;
        end else begin
            fs_q  <= fs_nxt;
            dco_q <= fs_nxt[0];
            if (fs_wrap) frame_q <= ~frame_q;
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset)             ds_q <= LAST;
        else if (slip_stretch) ds_q <= LAST;
        else if (ds_at_end)    ds_q <= '0;
        else                   ds_q <= ds_q + slot_t'(1);
    end

    // Pulses arriving while a slip is already pending are dropped.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset)             slip_pend_q <= 1'b0;
        else if (slip_stretch) slip_pend_q <= 1'b0;
        else if (bitslip)      slip_pend_q <= 1'b1;
    end

    // ---------------- word source selection ----------------
`ifdef SER_TESTPAT_EN
    assign tp_sel = tp_en;

    always_comb begin
        load_word = IDLE_WORD;
        if (tp_sel)           load_word = tp_word;
        else if (hold_full_q) load_word = hold_q;
    end
`else
    logic unused_tp;
    assign unused_tp = ^{tp_en, tp_word};
    assign tp_sel    = 1'b0;

    always_comb begin
        load_word = IDLE_WORD;
        if (hold_full_q) load_word = hold_q;
    end
`endif

    // Holding register drains only when the stream word is actually taken by the shifter.
    assign hold_pop      = load_now && hold_full_q && !tp_sel;
    assign s_if.s_ready  = !hold_full_q || hold_pop;
    assign accept        = s_if.s_valid && s_if.s_ready;

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else if (accept) begin
            hold_q      <= s_if.s_data;
            hold_full_q <= 1'b1;
        end else if (hold_pop) begin
            hold_full_q <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset)
            under_q <= '0;
        else if (load_now && !tp_sel && !hold_full_q && (under_q != 16'hFFFF))
            under_q <= under_q + 16'd1;
    end

    // ---------------- lanes ----------------
    // Lane l carries word bits W-1-l, W-1-l-2, ...; its first slot sits in the lane MSB.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [SLOTS-1:0] bits;
        for (genvar j = 0; j < SLOTS; j++) begin : g_slot
            assign bits[SLOTS-1-j] = load_word[W-1-l-NUM_LANES*j];
        end
        ltc_lvds_lane #(.SLOTS(SLOTS)) u_lane (
            .sys_clk   (sys_clk),
            .reset     (reset),
            .load      (load_now),
            .load_bits (bits),
            .dout      (lane_out[l])
        );
    end

    assign out_a        = lane_out[0];
    assign out_b        = lane_out[1];
    assign frame        = frame_q;
    assign dco          = dco_q;
    assign underrun_cnt = under_q;
endmodule

// File: tb/tb_ltc_lvds_serializer.sv
// Bench for ltc_lvds_serializer: a slot-queue reference model checked every cycle plus directed patterns.
module tb_ltc_lvds_serializer;
    localparam int           W     = 16;
    localparam int           SLOTS = W / 2;
    localparam logic [W-1:0] IDLE  = 16'h8001;
`ifdef SER_TESTPAT_EN
    localparam bit TP_ON = 1'b1;
`else
    localparam bit TP_ON = 1'b0;
`endif

    logic         sys_clk = 1'b0;
    logic         reset   = 1'b1;
    logic         bitslip = 1'b0;
    logic         tp_en   = 1'b0;
    logic [W-1:0] tp_word = '0;
    logic         out_a, out_b, frame, dco;
    logic [15:0]  underrun_cnt;

    ltc_lvds_serializer_if #(.W(W)) bus();

    ltc_lvds_serializer #(.W(W), .IDLE_WORD(IDLE)) dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .s_if         (bus),
        .bitslip      (bitslip),
        .tp_en        (tp_en),
        .tp_word      (tp_word),
        .out_a        (out_a),
        .out_b        (out_b),
        .frame        (frame),
        .dco          (dco),
        .underrun_cnt (underrun_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference: queue of lane-bit pairs still to emit, queue of held words, slip flag.
    bit [1:0]     pq[$];
    logic [W-1:0] hq[$];
    bit           m_pend, ea, eb, rdy_exp, rdy_got;
    int           m_under, k, m_src, m_off;
    logic [4:0]   exp_o, got_o;
    logic [15:0]  exp_u;
    int           total = 0, bad = 0;

    function automatic void model_reset();
        pq.delete(); hq.delete();
        m_pend = 0; m_under = 0; k = 0; ea = 0; eb = 0; m_src = 0; m_off = 0;
    endfunction

    // One clock: sample s_ready at negedge, advance the model at posedge, sample pins #1 later.
    task automatic tick();
        bit acc, old;
        logic [W-1:0] w;
        @(negedge sys_clk);
        rdy_got = bus.s_ready;
        rdy_exp = (hq.size() == 0) || (pq.size() == 0 && !m_pend && !(tp_en && TP_ON));
        @(posedge sys_clk);
        acc = bus.s_valid && rdy_exp;
        old = m_pend;
        k++;
        m_src = 0;
        if (pq.size() == 0 && old) begin
            ea = 0; eb = 0; m_pend = 0; m_src = 4;
        end else begin
            if (pq.size() == 0) begin
                m_off = (k - 1) % SLOTS;
                if (tp_en && TP_ON) begin w = tp_word; m_src = 1; end
                else if (hq.size() != 0) begin w = hq.pop_front(); m_src = 2; end
                else begin w = IDLE; m_src = 3; if (m_under < 65535) m_under++; end
                for (int i = SLOTS - 1; i >= 0; i--) pq.push_back(w[2*i +: 2]);
            end
            {ea, eb} = pq.pop_front();
        end
        if (acc) hq.push_back(bus.s_data);
        if (bitslip && !old) m_pend = 1;
        #1;
        got_o = {out_a, out_b, frame, dco, rdy_got};
        exp_o = {ea, eb, 1'(((k - 1) / SLOTS + 1) % 2), 1'(((k - 1) % SLOTS) % 2), rdy_exp};
        exp_u = 16'(m_under);
    endtask

    task automatic test_reset();
        bus.s_valid = 0; bus.s_data = '0; reset = 1;
        repeat (2) @(posedge sys_clk);
        #2;
        total++; if ({out_a, out_b, frame, dco, bus.s_ready} !== 5'b00001) begin
            bad++; $display("FAIL reset pins: got %b exp 00001", {out_a, out_b, frame, dco, bus.s_ready}); end
        total++; if (underrun_cnt !== 16'd0) begin
            bad++; $display("FAIL reset underrun: got %0d exp 0", underrun_cnt); end
        model_reset();
        #1 reset = 0;
        tick();
        total++; if (got_o !== exp_o) begin bad++; $display("FAIL first_edge pins: got %b exp %b", got_o, exp_o); end
        total++; if ({out_a, out_b, frame, dco} !== {IDLE[W-1], IDLE[W-2], 2'b10}) begin
            bad++; $display("FAIL first_edge idle: got %b exp %b", {out_a, out_b, frame, dco}, {IDLE[W-1], IDLE[W-2], 2'b10}); end
        total++; if (underrun_cnt !== 16'd1) begin bad++; $display("FAIL first_edge underrun: got %0d exp 1", underrun_cnt); end
    endtask

    task automatic test_single_word();
        logic [7:0] av, bv, fv, dv;
        bit found = 0;
        bus.s_data = 16'h000D; bus.s_valid = 1;
        tick();
        bus.s_valid = 0;
        total++; if (got_o !== exp_o) begin bad++; $display("FAIL single pins: got %b exp %b k=%0d", got_o, exp_o, k); end
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            total++; if (got_o !== exp_o) begin bad++; $display("FAIL single pins: got %b exp %b k=%0d", got_o, exp_o, k); end
            if (m_src == 2) found = 1;
        end
        total++; if (!found) begin bad++; $display("FAIL single timeout: got no load exp load within 20"); end
        for (int j = 0; j < 8; j++) begin
            if (j > 0) begin
                tick();
                total++; if (got_o !== exp_o) begin bad++; $display("FAIL single pins: got %b exp %b k=%0d", got_o, exp_o, k); end
            end
            av[7-j] = out_a; bv[7-j] = out_b; fv[7-j] = frame; dv[7-j] = dco;
        end
        total++; if (av !== 8'b0000_0010) begin bad++; $display("FAIL single lane_a: got %b exp 00000010", av); end
        total++; if (bv !== 8'b0000_0011) begin bad++; $display("FAIL single lane_b: got %b exp 00000011", bv); end
        total++; if (dv !== 8'b0101_0101) begin bad++; $display("FAIL single dco: got %b exp 01010101", dv); end
        total++; if (!(fv === 8'h00 || fv === 8'hFF)) begin bad++; $display("FAIL single frame: got %b exp constant", fv); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [3] = '{16'hA5A5, 16'h1234, 16'hFFFF};
        int idx = 0, nld = 0, ld [3];
        logic [15:0] u_first;
        bus.s_valid = 1;
        for (int c = 0; c < 60 && nld < 3; c++) begin
            bus.s_data = words[idx];
            tick();
            total++; if (got_o !== exp_o) begin bad++; $display("FAIL b2b pins: got %b exp %b k=%0d", got_o, exp_o, k); end
            if (bus.s_valid && rdy_exp) begin idx++; if (idx == 3) begin idx = 2; bus.s_valid = 0; end end
            if (m_src == 2) begin ld[nld] = k; if (nld == 0) u_first = exp_u; nld++; end
        end
        bus.s_valid = 0;
        total++; if (nld != 3) begin bad++; $display("FAIL b2b timeout: got %0d loads exp 3", nld); end
        else begin
            repeat (7) begin
                tick();
                total++; if (got_o !== exp_o) begin bad++; $display("FAIL b2b pins: got %b exp %b k=%0d", got_o, exp_o, k); end
            end
            total++; if (ld[1] - ld[0] != SLOTS || ld[2] - ld[1] != SLOTS) begin
                bad++; $display("FAIL b2b spacing: got %0d,%0d exp 8,8", ld[1] - ld[0], ld[2] - ld[1]); end
            total++; if (underrun_cnt !== u_first) begin bad++; $display("FAIL b2b underrun: got %0d exp %0d", underrun_cnt, u_first); end
        end
    endtask

    task automatic test_underrun();
        logic [7:0] av, bv;
        logic [15:0] ub;
        bit found = 0;
        bus.s_valid = 0;
        for (int c = 0; c < 30 && !found; c++) begin
            ub = exp_u;
            tick();
            total++; if (got_o !== exp_o) begin bad++; $display("FAIL underrun pins: got %b exp %b k=%0d", got_o, exp_o, k); end
            if (m_src == 3) found = 1;
        end
        total++; if (!found) begin bad++; $display("FAIL underrun timeout: got no idle exp idle within 30"); end
        for (int s = 0; s < 3 * SLOTS; s++) begin
            if (s > 0) begin
                tick();
                total++; if (got_o !== exp_o) begin bad++; $display("FAIL underrun pins: got %b exp %b k=%0d", got_o, exp_o, k); end
            end
            av[7 - s % 8] = out_a; bv[7 - s % 8] = out_b;
            if (s % 8 == 7) begin
                total++; if ({av, bv} !== 16'b1000_0000_0000_0001) begin
                    bad++; $display("FAIL underrun word%0d: got a=%b b=%b exp a=10000000 b=00000001", s / 8, av, bv); end
            end
        end
        total++; if (underrun_cnt !== ub + 16'd3) begin bad++; $display("FAIL underrun count: got %0d exp %0d", underrun_cnt, ub + 16'd3); end
    endtask

    task automatic test_bitslip();
        int got_off;
        bus.s_valid = 1; bus.s_data = 16'h000D;
        repeat (20) begin
            tick();
            total++; if (got_o !== exp_o) begin bad++; $display("FAIL bitslip pins: got %b exp %b k=%0d", got_o, exp_o, k); end
        end
        for (int n = 1; n <= 8; n++) begin
            bitslip = 1;
            tick();
            bitslip = 0;
            total++; if (got_o !== exp_o) begin bad++; $display("FAIL bitslip pins: got %b exp %b k=%0d", got_o, exp_o, k); end
            got_off = -1;
            for (int c = 0; c < 20; c++) begin
                tick();
                total++; if (got_o !== exp_o) begin bad++; $display("FAIL bitslip pins: got %b exp %b k=%0d", got_o, exp_o, k); end
                // 16'h000D drives lane A high only in slot 6 of its word.
                if (c >= 10 && out_a === 1'b1) got_off = (k - 7) % SLOTS;
            end
            total++; if (got_off != n % SLOTS) begin bad++; $display("FAIL bitslip offset%0d: got %0d exp %0d", n, got_off, n % SLOTS); end
        end
        bus.s_valid = 0;
    endtask

    task automatic test_testpat();
        tp_word = 16'h5555; tp_en = 1;
        bus.s_valid = 1; bus.s_data = 16'h3C3C;
        repeat (30) begin
            tick();
            total++; if (got_o !== exp_o) begin bad++; $display("FAIL testpat pins: got %b exp %b k=%0d", got_o, exp_o, k); end
            total++; if (underrun_cnt !== exp_u) begin bad++; $display("FAIL testpat underrun: got %0d exp %0d", underrun_cnt, exp_u); end
        end
        tp_en = 0; bus.s_valid = 0;
        repeat (20) begin
            tick();
            total++; if (got_o !== exp_o) begin bad++; $display("FAIL testpat_off pins: got %b exp %b k=%0d", got_o, exp_o, k); end
            total++; if (underrun_cnt !== exp_u) begin bad++; $display("FAIL testpat_off underrun: got %0d exp %0d", underrun_cnt, exp_u); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            bus.s_valid = 1'($urandom_range(0, 1));
            bus.s_data  = W'($urandom);
            bitslip     = ($urandom_range(0, 15) == 0);
            tp_en       = ($urandom_range(0, 3) == 0);
            tp_word     = W'($urandom);
            tick();
            total++; if (got_o !== exp_o) begin bad++; $display("FAIL random pins: got %b exp %b k=%0d", got_o, exp_o, k); end
            total++; if (underrun_cnt !== exp_u) begin bad++; $display("FAIL random underrun: got %0d exp %0d", underrun_cnt, exp_u); end
        end
        bus.s_valid = 0; bitslip = 0; tp_en = 0;
    endtask

    task automatic test_midword_reset();
        bit found = 0;
        bus.s_valid = 1; bus.s_data = 16'hFFFF;
        for (int c = 0; c < 40 && !found; c++) begin
            tick();
            total++; if (got_o !== exp_o) begin bad++; $display("FAIL midreset pins: got %b exp %b k=%0d", got_o, exp_o, k); end
            if (m_src == 2) found = 1;
        end
        total++; if (!found) begin bad++; $display("FAIL midreset timeout: got no load exp load within 40"); end
        repeat (3) begin
            tick();
            total++; if (got_o !== exp_o) begin bad++; $display("FAIL midreset pins: got %b exp %b k=%0d", got_o, exp_o, k); end
        end
        #2 reset = 1;
        #1;
        total++; if ({out_a, out_b, frame, dco, bus.s_ready} !== 5'b00001) begin
            bad++; $display("FAIL midreset async: got %b exp 00001", {out_a, out_b, frame, dco, bus.s_ready}); end
        total++; if (underrun_cnt !== 16'd0) begin bad++; $display("FAIL midreset underrun0: got %0d exp 0", underrun_cnt); end
        model_reset();
        bus.s_valid = 0;
        @(posedge sys_clk);
        #2 reset = 0;
        tick();
        total++; if (got_o !== exp_o) begin bad++; $display("FAIL midreset after pins: got %b exp %b", got_o, exp_o); end
        total++; if ({out_a, out_b} !== {IDLE[W-1], IDLE[W-2]}) begin
            bad++; $display("FAIL midreset idle: got %b exp %b", {out_a, out_b}, {IDLE[W-1], IDLE[W-2]}); end
        total++; if (underrun_cnt !== 16'd1) begin bad++; $display("FAIL midreset underrun1: got %0d exp 1", underrun_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_underrun();
        test_bitslip();
        test_testpat();
        test_random();
        test_midword_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish exp finish by 200000");
        $fatal(1);
    end
endmodule
